// File: rtl/m68k_txn_queue.sv
// m68k_txn_queue: FIFO of Pi-issued 68k bus transactions feeding the bus cycle FSM.
// Optional bus watchdog enabled by defining M68K_TXN_TIMEOUT_EN.
`default_nettype none

module m68k_txn_queue #(
    parameter int DEPTH_LOG2     = 2,
    parameter int ADDR_W         = 24,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                  PI_CLK,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic                  in_rw,
    input  logic                  in_byte,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_wdata,
    output logic                  in_ready,
    output logic                  op_req,
    output logic                  op_rw,
    output logic                  op_uds_n,
    output logic                  op_lds_n,
    output logic [ADDR_W-1:0]     op_addr,
    output logic [DATA_W-1:0]     op_wdata,
    input  logic                  op_res,
    input  logic [DATA_W-1:0]     op_rdata,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  txn_in_progress,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  timeout_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                state;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  read_pending;

    logic [ADDR_W-1:0] mem_addr  [DEPTH];
    logic [DATA_W-1:0] mem_wdata [DEPTH];
    logic              mem_rw    [DEPTH];
    logic              mem_uds_n [DEPTH];
    logic              mem_lds_n [DEPTH];

    logic              push;
    logic              pop;
    logic              expire;
    logic              new_uds_n;
    logic              new_lds_n;
    logic [ADDR_W-1:0] new_addr;

    assign in_ready        = (level != FULL_LEVEL) && !read_pending;
    assign push            = in_valid && in_ready;
    assign pop             = (state == S_WAIT) && (op_res || expire);
    assign txn_in_progress = (level != '0) || (state != S_IDLE);

    assign new_uds_n = in_byte ? in_addr[0]  : 1'b0;
    assign new_lds_n = in_byte ? !in_addr[0] : 1'b0;
    assign new_addr  = {in_addr[ADDR_W-1:1], 1'b0};

`ifdef M68K_TXN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    assign expire = (state == S_WAIT) && !op_res && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign timeout_err    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Storage has no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge PI_CLK) begin
        if (push) begin
            mem_addr[wr_ptr]  <= new_addr;
            mem_wdata[wr_ptr] <= in_wdata;
            mem_rw[wr_ptr]    <= in_rw;
            mem_uds_n[wr_ptr] <= new_uds_n;
            mem_lds_n[wr_ptr] <= new_lds_n;
        end
    end

    always_ff @(posedge PI_CLK) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            read_pending <= 1'b0;
            op_req       <= 1'b0;
            op_rw        <= 1'b1;
            op_uds_n     <= 1'b1;
            op_lds_n     <= 1'b1;
            op_addr      <= '0;
            op_wdata     <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            overflow     <= 1'b0;
`ifdef M68K_TXN_TIMEOUT_EN
            tcnt         <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            op_req <= 1'b0;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (push && !pop)      level <= level + 1'b1;
            else if (!push && pop) level <= level - 1'b1;

            if (in_valid && !in_ready) overflow <= 1'b1;

            if (push && in_rw) begin
                read_pending <= 1'b1;
                rd_valid     <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    // An entry arriving into an empty queue is issued straight
                    // from the inputs so op_req follows in_valid by one cycle.
                    if (level != '0) begin
                        op_rw    <= mem_rw[rd_ptr];
                        op_uds_n <= mem_uds_n[rd_ptr];
                        op_lds_n <= mem_lds_n[rd_ptr];
                        op_addr  <= mem_addr[rd_ptr];
                        op_wdata <= mem_wdata[rd_ptr];
                        op_req   <= 1'b1;
                        state    <= S_WAIT;
                    end else if (push) begin
                        op_rw    <= in_rw;
                        op_uds_n <= new_uds_n;
                        op_lds_n <= new_lds_n;
                        op_addr  <= new_addr;
                        op_wdata <= in_wdata;
                        op_req   <= 1'b1;
                        state    <= S_WAIT;
                    end
`ifdef M68K_TXN_TIMEOUT_EN
                    tcnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (op_res) begin
                        state <= S_IDLE;
                        if (op_rw) begin
                            rd_data      <= op_rdata;
                            rd_valid     <= 1'b1;
                            read_pending <= 1'b0;
                        end
`ifdef M68K_TXN_TIMEOUT_EN
                    end else if (expire) begin
                        state       <= S_IDLE;
                        timeout_err <= 1'b1;
                        if (op_rw) begin
                            rd_data      <= '1;
                            rd_valid     <= 1'b1;
                            read_pending <= 1'b0;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
